pipe_de_skid: RTL and testbench

Parametrised decode→execute pipeline stage for the vector datapath. It carries the execute control word, NUM_D data lanes, operands A/B and the write-back register address from decode to execute. Unlike a bare per-cycle register it has a valid/ready handshake with a two-entry skid buffer, a synchronous flush, and suppression of write enables on bubbles. It sits between the decode/register-read logic and the ALU/memory-address stage.

---
 rtl/pipe_de_skid_pkg.sv | 45 ++++
 rtl/pipe_de_skid_if.sv | 48 ++++
 rtl/pipe_skid_buf.sv | 107 ++++++++++
 rtl/pipe_de_skid.sv | 87 ++++++++
 tb/tb_pipe_de_skid.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_de_skid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg (package)
// Description : Shared types and default widths for the decode->execute
//               pipeline stage and its generic skid buffer.
//               - de_ctrl_t    : packed execute control word
//               - skid_state_e : skid-buffer occupancy state
//               - payload_w()  : total packed payload width helper
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int ALU_OP_W   = 4;   // ALU opcode width, identical on both sides
    localparam int MUX_RES_W  = 2;   // result-select width
    localparam int ADDR_W_DEF = 5;   // default register address width
    localparam int DATA_W_DEF = 32;  // default lane / operand width
    localparam int NUM_D_DEF  = 25;  // default number of data lanes

    // Execute control word; write enables sit in the two LSBs.
    typedef struct packed {
        logic [ALU_OP_W-1:0]  alu_op;
        logic [MUX_RES_W-1:0] mux_result;
        logic                 mux_dir_write;
        logic                 mux_dir_mem;
        logic                 mux_dato;
        logic                 write_mem;
        logic                 write_reg;
    } de_ctrl_t;

    localparam int CTRL_W = $bits(de_ctrl_t);

    // EMPTY: main invalid; BUSY: main valid, skid empty; FULL: both valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    // Payload = ctrl + lanes + operand A + operand B + write address.
    function automatic int payload_w(input int num_d, input int data_w, input int addr_w);
        return CTRL_W + num_d * data_w + 2 * data_w + addr_w;
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_de_skid_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_de_skid_if (interface)
// Description : Valid/ready handshake plus decode->execute payload.
//               master : drives valid and payload, receives ready
//               slave  : receives valid and payload, drives ready
//               Signals: valid, ready, alu_op, mux_result, mux_dir_write,
//               mux_dir_mem, mux_dato, write_mem, write_reg,
//               data (lane i at [i*DATA_W +: DATA_W]), val_a, val_b,
//               dir_write.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_de_skid_if
    import pipe_pkg::*;
#(
    parameter int NUM_D  = NUM_D_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic                    valid;
    logic                    ready;
    logic [ALU_OP_W-1:0]     alu_op;
    logic [MUX_RES_W-1:0]    mux_result;
    logic                    mux_dir_write;
    logic                    mux_dir_mem;
    logic                    mux_dato;
    logic                    write_mem;
    logic                    write_reg;
    logic [NUM_D*DATA_W-1:0] data;
    logic [DATA_W-1:0]       val_a;
    logic [DATA_W-1:0]       val_b;
    logic [ADDR_W-1:0]       dir_write;

    modport master (
        output valid, alu_op, mux_result, mux_dir_write, mux_dir_mem, mux_dato,
               write_mem, write_reg, data, val_a, val_b, dir_write,
        input  ready
    );

    modport slave (
        input  valid, alu_op, mux_result, mux_dir_write, mux_dir_mem, mux_dato,
               write_mem, write_reg, data, val_a, val_b, dir_write,
        output ready
    );

endinterface : pipe_de_skid_if
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_buf
// Description : Generic two-entry (main + skid) valid/ready pipeline register
//               with synchronous flush. Fully registered: in_ready_o depends
//               only on stored state, never combinationally on out_ready_i.
// Ports       : clk           in   clock, rising edge
//               rst_n         in   synchronous active-low reset
//               flush_i       in   drop both entries (and a same-cycle accept)
//               in_valid_i    in   upstream valid
//               in_ready_o    out  stage can accept (registered)
//               in_payload_i  in   upstream payload
//               out_valid_o   out  main entry valid
//               out_ready_i   in   downstream accepts
//               out_payload_o out  main entry payload
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PAYLOAD_W-1:0] in_payload_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PAYLOAD_W-1:0] out_payload_o
);

    skid_state_e          state_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [PAYLOAD_W-1:0] main_q;
    logic [PAYLOAD_W-1:0] skid_q;

    logic accept;
    logic pop;

    assign accept = in_valid_i  & in_ready_q;
    assign pop    = out_valid_q & out_ready_i;

    // in_ready_q and out_valid_q are updated together with state_q so that
    // in_ready_q == (state_q != FULL) and out_valid_q == (state_q != EMPTY)
    // hold at every edge, except that in_ready_q stays low for the first
    // cycle after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
        end else if (flush_i) begin
            // Flush wins over accept and pop; payload contents are left as-is
            // because out_valid_q alone marks them dead.
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        main_q      <= in_payload_i;
                        state_q     <= ST_BUSY;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (accept && pop) begin
                        main_q <= in_payload_i;
                    end else if (accept) begin
                        // Downstream stalled: park the new payload behind main.
                        skid_q     <= in_payload_i;
                        state_q    <= ST_FULL;
                        in_ready_q <= 1'b0;
                    end else if (pop) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        main_q     <= skid_q;
                        state_q    <= ST_BUSY;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = out_valid_q;
    assign out_payload_o = main_q;

endmodule : pipe_skid_buf
`default_nettype wire

// File: rtl/pipe_de_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_de_skid
// Description : Decode->execute pipeline stage. Packs control word, NUM_D
//               data lanes, operands A/B and write-back address into one
//               payload, carries it through a two-entry skid buffer, and
//               forces the write enables low whenever the output is a bubble.
//               The ALU opcode width is fixed by pipe_pkg::ALU_OP_W.
// Ports       : clk     in   clock, rising edge
//               rst_n   in   synchronous active-low reset
//               flush   in   synchronous kill of all held entries
//               in_if   slave  upstream handshake + payload (in_*)
//               out_if  master downstream handshake + payload (out_*)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_de_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NUM_D  = NUM_D_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    pipe_de_skid_if.slave  in_if,
    pipe_de_skid_if.master out_if
);

    localparam int DATA_BITS = NUM_D * DATA_W;
    localparam int PAYLOAD_W = payload_w(NUM_D, DATA_W, ADDR_W);

    // Payload field offsets, LSB first: dir_write, val_b, val_a, data, ctrl.
    localparam int OFS_VB   = ADDR_W;
    localparam int OFS_VA   = OFS_VB + DATA_W;
    localparam int OFS_DATA = OFS_VA + DATA_W;
    localparam int OFS_CTRL = OFS_DATA + DATA_BITS;

    de_ctrl_t               in_ctrl;
    de_ctrl_t               out_ctrl;
    logic [PAYLOAD_W-1:0]   in_payload;
    logic [PAYLOAD_W-1:0]   out_payload;
    logic                   out_valid;

    assign in_ctrl.alu_op        = in_if.alu_op;
    assign in_ctrl.mux_result    = in_if.mux_result;
    assign in_ctrl.mux_dir_write = in_if.mux_dir_write;
    assign in_ctrl.mux_dir_mem   = in_if.mux_dir_mem;
    assign in_ctrl.mux_dato      = in_if.mux_dato;
    assign in_ctrl.write_mem     = in_if.write_mem;
    assign in_ctrl.write_reg     = in_if.write_reg;

    assign in_payload = {in_ctrl, in_if.data, in_if.val_a, in_if.val_b, in_if.dir_write};

    pipe_skid_buf #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush),
        .in_valid_i    (in_if.valid),
        .in_ready_o    (in_if.ready),
        .in_payload_i  (in_payload),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_if.ready),
        .out_payload_o (out_payload)
    );

    assign out_ctrl = out_payload[OFS_CTRL +: CTRL_W];

    assign out_if.valid         = out_valid;
    assign out_if.alu_op        = out_ctrl.alu_op;
    assign out_if.mux_result    = out_ctrl.mux_result;
    assign out_if.mux_dir_write = out_ctrl.mux_dir_write;
    assign out_if.mux_dir_mem   = out_ctrl.mux_dir_mem;
    assign out_if.mux_dato      = out_ctrl.mux_dato;
    // A flushed or drained entry keeps its old payload; the enables must not
    // leak through on such a bubble.
    assign out_if.write_mem     = out_ctrl.write_mem & out_valid;
    assign out_if.write_reg     = out_ctrl.write_reg & out_valid;
    assign out_if.data          = out_payload[OFS_DATA +: DATA_BITS];
    assign out_if.val_a         = out_payload[OFS_VA +: DATA_W];
    assign out_if.val_b         = out_payload[OFS_VB +: DATA_W];
    assign out_if.dir_write     = out_payload[0 +: ADDR_W];

endmodule : pipe_de_skid
`default_nettype wire

// File: tb/tb_pipe_de_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_de_skid
// Description : Self-checking bench for pipe_de_skid. Drives a wide instance
//               (NUM_D=25, DATA_W=32) and a narrow one (NUM_D=1, DATA_W=8)
//               with the same handshake vectors, then runs a scoreboarded
//               stream with intermittent backpressure on the wide instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_de_skid;

    logic clk;
    logic rst_n;
    logic flush;

    pipe_de_skid_if #(.NUM_D(25), .DATA_W(32), .ADDR_W(5)) big_in ();
    pipe_de_skid_if #(.NUM_D(25), .DATA_W(32), .ADDR_W(5)) big_out ();
    pipe_de_skid_if #(.NUM_D(1),  .DATA_W(8),  .ADDR_W(5)) sml_in ();
    pipe_de_skid_if #(.NUM_D(1),  .DATA_W(8),  .ADDR_W(5)) sml_out ();

    pipe_de_skid #(.DATA_W(32), .NUM_D(25), .ADDR_W(5)) u_big (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .in_if  (big_in),
        .out_if (big_out)
    );

    pipe_de_skid #(.DATA_W(8), .NUM_D(1), .ADDR_W(5)) u_sml (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .in_if  (sml_in),
        .out_if (sml_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // exp_seq: >0 compare full payload of that seq, 0 don't care, -1 all zero.
    typedef struct {
        bit rst_n;
        bit flush;
        bit in_valid;
        bit out_ready;
        int seq;
        bit exp_valid;
        bit exp_ready;
        int exp_seq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(bit r, bit f, bit iv, bit ordy, int seq, bit ev, bit er, int es);
        vec_t v;
        v.rst_n = r; v.flush = f; v.in_valid = iv; v.out_ready = ordy;
        v.seq = seq; v.exp_valid = ev; v.exp_ready = er; v.exp_seq = es;
        return v;
    endfunction

    // Payload recipe per sequence number (bench-side reference).
    function automatic logic [10:0] ctrl_of(int seq);
        logic [31:0] s;
        s = 32'(seq);
        return {s[3:0] ^ 4'hA, s[2:1], s[2], s[3], ~s[4], s[0], s[1]};
    endfunction

    function automatic logic [31:0] va_of(int seq);
        return 32'(32'hA000_0000 + 32'(seq));
    endfunction

    function automatic logic [31:0] vb_of(int seq);
        return 32'h5B00_0000 ^ 32'(seq * 16 + 3);
    endfunction

    function automatic logic [799:0] lanes_big(int seq);
        logic [799:0] r;
        r = '0;
        for (int i = 0; i < 25; i++) r[i*32 +: 32] = 32'(32'h1000_0000 + 32'(seq * 32 + i));
        return r;
    endfunction

    function automatic logic [7:0] lane_sml(int seq);
        return 8'(seq * 7 + 17);
    endfunction

    task automatic chk(input string name, input int vi, input logic [799:0] act, input logic [799:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL vec=%0d %s act=%0h exp=%0h", vi, name, act, exp);
        end
    endtask

    task automatic drive_payload(input int seq);
        logic [10:0] c;
        c = (seq > 0) ? ctrl_of(seq) : 11'd0;
        {big_in.alu_op, big_in.mux_result, big_in.mux_dir_write, big_in.mux_dir_mem,
         big_in.mux_dato, big_in.write_mem, big_in.write_reg} = c;
        {sml_in.alu_op, sml_in.mux_result, sml_in.mux_dir_write, sml_in.mux_dir_mem,
         sml_in.mux_dato, sml_in.write_mem, sml_in.write_reg} = c;
        big_in.data      = (seq > 0) ? lanes_big(seq) : '0;
        big_in.val_a     = (seq > 0) ? va_of(seq) : '0;
        big_in.val_b     = (seq > 0) ? vb_of(seq) : '0;
        big_in.dir_write = 5'(seq);
        sml_in.data      = (seq > 0) ? lane_sml(seq) : '0;
        sml_in.val_a     = (seq > 0) ? 8'(va_of(seq)) : '0;
        sml_in.val_b     = (seq > 0) ? 8'(vb_of(seq)) : '0;
        sml_in.dir_write = 5'(seq);
    endtask

    function automatic logic [10:0] big_ctrl_act();
        return {big_out.alu_op, big_out.mux_result, big_out.mux_dir_write, big_out.mux_dir_mem,
                big_out.mux_dato, big_out.write_mem, big_out.write_reg};
    endfunction

    function automatic logic [10:0] sml_ctrl_act();
        return {sml_out.alu_op, sml_out.mux_result, sml_out.mux_dir_write, sml_out.mux_dir_mem,
                sml_out.mux_dato, sml_out.write_mem, sml_out.write_reg};
    endfunction

    task automatic check_vec(input int vi, input vec_t v);
        logic [10:0] ec;
        logic [1:0]  ewe;
        ec  = (v.exp_seq > 0) ? ctrl_of(v.exp_seq) : 11'd0;
        ewe = v.exp_valid ? ec[1:0] : 2'b00;
        chk("big.out_valid", vi, 800'(big_out.valid), 800'(v.exp_valid));
        chk("big.in_ready",  vi, 800'(big_in.ready),  800'(v.exp_ready));
        chk("big.write_en",  vi, 800'({big_out.write_mem, big_out.write_reg}), 800'(ewe));
        chk("sml.out_valid", vi, 800'(sml_out.valid), 800'(v.exp_valid));
        chk("sml.in_ready",  vi, 800'(sml_in.ready),  800'(v.exp_ready));
        chk("sml.write_en",  vi, 800'({sml_out.write_mem, sml_out.write_reg}), 800'(ewe));
        if (v.exp_seq != 0) begin
            chk("big.ctrl",  vi, 800'(big_ctrl_act()), 800'(ec));
            chk("big.data",  vi, big_out.data, (v.exp_seq > 0) ? lanes_big(v.exp_seq) : 800'd0);
            chk("big.ops",   vi, 800'({big_out.val_a, big_out.val_b, big_out.dir_write}),
                (v.exp_seq > 0) ? 800'({va_of(v.exp_seq), vb_of(v.exp_seq), 5'(v.exp_seq)}) : 800'd0);
            chk("sml.ctrl",  vi, 800'(sml_ctrl_act()), 800'(ec));
            chk("sml.lane0", vi, 800'(sml_out.data), (v.exp_seq > 0) ? 800'(lane_sml(v.exp_seq)) : 800'd0);
            chk("sml.ops",   vi, 800'({sml_out.val_a, sml_out.val_b, sml_out.dir_write}),
                (v.exp_seq > 0) ? 800'({8'(va_of(v.exp_seq)), 8'(vb_of(v.exp_seq)), 5'(v.exp_seq)}) : 800'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        big_in.valid  = 1'b0;
        sml_in.valid  = 1'b0;
        big_out.ready = 1'b0;
        sml_out.ready = 1'b0;
        drive_payload(0);

        // Reset with valid asserted; in_ready rises one edge after release.
        vecs.push_back(mkv(0,0,1,1, 1, 0,0,-1));
        vecs.push_back(mkv(0,0,1,1, 1, 0,0,-1));
        vecs.push_back(mkv(1,0,1,1, 1, 0,1,-1));
        // Streaming: one-cycle latency, in_ready stays high.
        for (int k = 1; k <= 10; k++) vecs.push_back(mkv(1,0,1,1, k, 1,1,k));
        vecs.push_back(mkv(1,0,0,1, 0, 0,1,0));
        // Backpressure for three cycles: skid fills, nothing lost.
        vecs.push_back(mkv(1,0,1,1, 11, 1,1,11));
        vecs.push_back(mkv(1,0,1,1, 12, 1,1,12));
        vecs.push_back(mkv(1,0,1,0, 13, 1,0,12));
        vecs.push_back(mkv(1,0,1,0, 14, 1,0,12));
        vecs.push_back(mkv(1,0,1,0, 14, 1,0,12));
        vecs.push_back(mkv(1,0,1,1, 14, 1,1,13));
        vecs.push_back(mkv(1,0,1,1, 14, 1,1,14));
        vecs.push_back(mkv(1,0,0,1, 0,  0,1,0));
        // Flush while FULL with valid high.
        vecs.push_back(mkv(1,0,1,0, 15, 1,1,15));
        vecs.push_back(mkv(1,0,1,0, 16, 1,0,15));
        vecs.push_back(mkv(1,1,1,0, 17, 0,1,0));
        vecs.push_back(mkv(1,0,0,1, 0,  0,1,0));
        // Flush beats a same-cycle accept and pop.
        vecs.push_back(mkv(1,0,1,1, 18, 1,1,18));
        vecs.push_back(mkv(1,1,1,1, 19, 0,1,0));
        vecs.push_back(mkv(1,0,0,1, 0,  0,1,0));
        // Bubble gating: seq 3 has both write enables set.
        vecs.push_back(mkv(1,0,1,0, 3, 1,1,3));
        vecs.push_back(mkv(1,0,0,0, 0, 1,1,3));
        vecs.push_back(mkv(1,1,0,0, 0, 0,1,0));
        vecs.push_back(mkv(1,0,0,1, 0, 0,1,0));
        // Reset mid-operation discards both entries, nothing replays.
        vecs.push_back(mkv(1,0,1,0, 20, 1,1,20));
        vecs.push_back(mkv(1,0,1,0, 21, 1,0,20));
        vecs.push_back(mkv(0,0,1,1, 21, 0,0,-1));
        vecs.push_back(mkv(1,0,0,1, 0,  0,1,-1));
        vecs.push_back(mkv(1,0,0,1, 0,  0,1,-1));

        for (int vi = 0; vi < vecs.size(); vi++) begin
            rst_n         = vecs[vi].rst_n;
            flush         = vecs[vi].flush;
            big_in.valid  = vecs[vi].in_valid;
            sml_in.valid  = vecs[vi].in_valid;
            big_out.ready = vecs[vi].out_ready;
            sml_out.ready = vecs[vi].out_ready;
            drive_payload(vecs[vi].seq);
            @(posedge clk);
            #1;
            check_vec(vi, vecs[vi]);
        end

        // Scoreboarded stream with out_ready low every third cycle.
        begin
            int exp_q[$];
            int nxt;
            int cyc;
            bit acc;
            int es;
            nxt = 30;
            cyc = 0;
            flush = 1'b0;
            rst_n = 1'b1;
            while (cyc < 200 && (nxt < 46 || exp_q.size() > 0)) begin
                big_in.valid  = (nxt < 46);
                sml_in.valid  = 1'b0;
                sml_out.ready = 1'b1;
                drive_payload(nxt);
                big_out.ready = (cyc % 3) != 1;
                #1;
                acc = big_in.valid && big_in.ready;
                if (big_out.valid && big_out.ready) begin
                    if (exp_q.size() == 0) begin
                        chk("sb.unexpected_pop", cyc, 800'(1), 800'(0));
                    end else begin
                        es = exp_q.pop_front();
                        chk("sb.data", cyc, big_out.data, lanes_big(es));
                        chk("sb.ctrl", cyc, 800'(big_ctrl_act()), 800'(ctrl_of(es)));
                    end
                end
                @(posedge clk);
                #1;
                if (acc) begin
                    exp_q.push_back(nxt);
                    nxt++;
                end
                cyc++;
            end
            chk("sb.all_sent",    cyc, 800'(nxt), 800'(46));
            chk("sb.all_drained", cyc, 800'(exp_q.size()), 800'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipe_de_skid
`default_nettype wire
